// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state codes, frame byte order and word packing.
package boot_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] LEN_LO  = 4'd0;
  localparam logic [STATE_W-1:0] LEN_HI  = 4'd1;
  localparam logic [STATE_W-1:0] DATA_LO = 4'd2;
  localparam logic [STATE_W-1:0] DATA_HI = 4'd3;
  localparam logic [STATE_W-1:0] WRITE   = 4'd4;
  localparam logic [STATE_W-1:0] CHK_LO  = 4'd5;
  localparam logic [STATE_W-1:0] CHK_HI  = 4'd6;
  localparam logic [STATE_W-1:0] RUN     = 4'd7;
  localparam logic [STATE_W-1:0] ERROR   = 4'd8;

  // Frames carry every 16-bit quantity low byte first.
  localparam bit FRAME_LSB_FIRST = 1'b1;

  function automatic logic [15:0] pack_word(input logic [7:0] first_b, input logic [7:0] second_b);
    return FRAME_LSB_FIRST ? {second_b, first_b} : {first_b, second_b};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and ROM write port of the boot loader.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, rom_we, rom_addr, rom_wdata
  );
endinterface

// File: rtl/idle_timer.sv
// Loadable down-counter: clr_i reloads TIMEOUT, en_i counts one idle cycle,
// expire_o flags the idle cycle that exhausts the budget.
module idle_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(TIMEOUT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CNT_W'(TIMEOUT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed byte frame, writes it to instruction ROM, then releases the CPU.
// Optional trailing 16-bit checksum enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 32768,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reload,
  boot_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         error
);
  localparam int unsigned CNT_W = 16;

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         lo_q, lo_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               rom_we_q, rom_we_d;
  logic [15:0]        rom_wdata_q, rom_wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0]        sum_q, sum_d;
`endif

  logic        rx_ready_c;
  logic        accept_c;
  logic        expire_c;
  logic [15:0] rx_word_c;

  assign rx_ready_c = state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK_LO, CHK_HI};
  assign accept_c   = bus.rx_valid & rx_ready_c;
  assign rx_word_c  = pack_word(lo_q, bus.rx_data);

  // Inter-byte idle watchdog; LEN_LO is excluded so the loader may wait forever for a frame.
  if (TIMEOUT != 0) begin : g_timer
    logic count_c;
    assign count_c = state_q inside {LEN_HI, DATA_LO, DATA_HI, CHK_LO, CHK_HI};

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (accept_c | reload),
      .en_i     (count_c & ~accept_c),
      .expire_o (expire_c)
    );
  end else begin : g_no_timer
    assign expire_c = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    remain_d    = remain_q;
    rom_addr_d  = rom_addr_q;
    rom_we_d    = 1'b0;
    rom_wdata_d = rom_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (reload) begin
      // Reload beats any byte accepted in the same cycle.
      state_d     = LEN_LO;
      remain_d    = '0;
      rom_addr_d  = '0;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_d       = '0;
`endif
    end else if (expire_c) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        LEN_LO: begin
          if (accept_c) begin
            lo_d    = bus.rx_data;
            state_d = LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept_c) begin
            if (rx_word_c == 16'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state_d = CHK_LO;
`else
              state_d = RUN;
`endif
            end else if (32'(rx_word_c) > MAX_WORDS) begin
              state_d = ERROR;
            end else begin
              remain_d   = rx_word_c;
              rom_addr_d = '0;
              state_d    = DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (accept_c) begin
            lo_d    = bus.rx_data;
            state_d = DATA_HI;
          end
        end
        DATA_HI: begin
          if (accept_c) begin
            rom_we_d    = 1'b1;
            rom_wdata_d = rx_word_c;
            state_d     = WRITE;
          end
        end
        WRITE: begin
          remain_d = remain_q - CNT_W'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
          sum_d    = sum_q + rom_wdata_q;
`endif
          // The address stays on the last word so it never walks past the program length.
          if (remain_q == CNT_W'(1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_d = CHK_LO;
`else
            state_d = RUN;
`endif
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = DATA_LO;
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        CHK_LO: begin
          if (accept_c) begin
            lo_d    = bus.rx_data;
            state_d = CHK_HI;
          end
        end
        CHK_HI: begin
          if (accept_c) begin
            state_d = (rx_word_c == sum_q) ? RUN : ERROR;
          end
        end
`endif
        RUN: begin
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end
        ERROR: begin
          cpu_reset_d = 1'b1;
        end
        default: begin
          state_d = ERROR;
        end
      endcase
    end

    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LEN_LO;
      lo_q        <= '0;
      remain_q    <= '0;
      rom_addr_q  <= '0;
      rom_we_q    <= 1'b0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      remain_q    <= remain_d;
      rom_addr_q  <= rom_addr_d;
      rom_we_q    <= rom_we_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_c;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: frame-level reference model plus directed literal checks.
module tb_boot_loader;

  localparam int TO   = 16;
  localparam int MAXW = 32768;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic cpu_reset, done, error;

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(15)) bus ();

  boot_loader #(.ADDR_W(15), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .reload    (reload),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: counts accepted bytes in the frame and derives what must happen from the byte index.
  bit          m_load, m_wr, m_armed, m_run, m_err, m_acc, m_nwr;
  int          m_got, m_len, m_idle, m_waddr, m_d;
  logic [15:0] m_wdata, m_sum;
  logic [7:0]  m_lo;

  function automatic bit m_ready();
    return m_load && !m_wr && !m_err;
  endfunction

  task automatic m_init();
    m_load = 1'b1; m_wr = 1'b0; m_armed = 1'b0; m_run = 1'b0; m_err = 1'b0;
    m_got = 0; m_idle = 0; m_sum = 16'h0;
  endtask

  task automatic m_finish();
    m_load  = 1'b0;
    m_armed = 1'b1;
  endtask

  task automatic m_fail();
    m_load = 1'b0;
    m_err  = 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset || reload) begin
      m_init();
    end else begin
      m_acc = bus.rx_valid && m_ready();
      m_nwr = 1'b0;
      if (m_armed) begin
        m_run   = 1'b1;
        m_armed = 1'b0;
      end
      if (m_wr) begin
        m_sum = m_sum + m_wdata;
        if (m_waddr == m_len - 1 && !CHK) m_finish();
      end else if (m_acc) begin
        m_got++;
        m_idle = 0;
        if (m_got == 1) begin
          m_lo = bus.rx_data;
        end else if (m_got == 2) begin
          m_len = 32'({bus.rx_data, m_lo});
          if (m_len == 0) begin
            if (!CHK) m_finish();
          end else if (m_len > MAXW) begin
            m_fail();
          end
        end else if (m_got <= 2 + 2 * m_len) begin
          m_d = m_got - 3;
          if (m_d % 2 == 0) begin
            m_lo = bus.rx_data;
          end else begin
            m_nwr   = 1'b1;
            m_waddr = m_d / 2;
            m_wdata = {bus.rx_data, m_lo};
          end
        end else if (m_got == 3 + 2 * m_len) begin
          m_lo = bus.rx_data;
        end else begin
          if ({bus.rx_data, m_lo} == m_sum) m_finish();
          else m_fail();
        end
      end else if (m_load && m_got > 0) begin
        m_idle++;
        if (m_idle >= TO) m_fail();
      end
      m_wr = m_nwr;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rx_ready", 32'(bus.rx_ready), 32'(m_ready()));
      chk("rom_we", 32'(bus.rom_we), 32'(m_wr));
      if (m_wr && bus.rom_we) begin
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_waddr));
        chk("rom_wdata", 32'(bus.rom_wdata), 32'(m_wdata));
      end
      chk("cpu_reset", 32'(cpu_reset), 32'(!m_run));
      chk("done", 32'(done), 32'(m_run));
      chk("error", 32'(error), 32'(m_err));
      if (bus.rom_we) wlog.push_back({16'(bus.rom_addr), bus.rom_wdata});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; reload = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_rom_wdata", 32'(bus.rom_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Two-word program.
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hCD); send_byte(8'hAB);
    if (CHK) begin send_byte(8'h01); send_byte(8'hBE); end
    wait_done();
    chk("t1_nwrites", 32'(wlog.size()), 32'd2);
    chk("t1_w0", wlog[0], 32'h0000_1234);
    chk("t1_w1", wlog[1], 32'h0001_ABCD);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);

    // Reload while running, then a one-word program.
    repeat (3) @(negedge clk);
    pulse_reload();
    chk("t2_cpu_reset_up", 32'(cpu_reset), 32'd1);
    chk("t2_done_low", 32'(done), 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h00);
    if (CHK) begin send_byte(8'hFF); send_byte(8'h00); end
    wait_done();
    chk("t2_w", wlog[wlog.size()-1], 32'h0000_00FF);

    // Empty program.
    pulse_reload();
    send_byte(8'h00); send_byte(8'h00);
    if (CHK) begin send_byte(8'h00); send_byte(8'h00); end
    repeat (2) @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t3_nwrites", 32'(wlog.size()), 32'd3);

    // Oversize length.
    pulse_reload();
    send_byte(8'h01); send_byte(8'h80);
    @(negedge clk);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t4_rx_ready", 32'(bus.rx_ready), 32'd0);

    // Inter-byte timeout, then recovery through reload.
    pulse_reload();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h34);
    repeat (20) @(negedge clk);
    chk("t5_error", 32'(error), 32'd1);
    pulse_reload();
    chk("t5_error_clr", 32'(error), 32'd0);
    chk("t5_rx_ready", 32'(bus.rx_ready), 32'd1);

    // Reload coinciding with a byte: the byte is dropped.
    bus.rx_data = 8'h05; bus.rx_valid = 1'b1; reload = 1'b1;
    @(negedge clk);
    reload = 1'b0; bus.rx_valid = 1'b0;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h77); send_byte(8'h66);
    if (CHK) begin send_byte(8'h77); send_byte(8'h66); end
    wait_done();
    chk("t6_w", wlog[wlog.size()-1], 32'h0000_6677);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    pulse_reload();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h12);
    wait_done();
    chk("t7_error", 32'(error), 32'd0);
    pulse_reload();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h35); send_byte(8'h12);
    @(negedge clk);
    chk("t7_bad_error", 32'(error), 32'd1);
    chk("t7_bad_done", 32'(done), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sequences CPU bring-up. Holds the CPU in reset while a byte stream (from the UART receiver) is written into instruction ROM as 16-bit words, then releases the CPU to run from address 0.
- Sits between the serial receiver, the instruction ROM write port and the CPU `reset` input.
- Re-entering load mode through `reload` halts the CPU and rewrites the program.

Parameters:
- ADDR_W, 15, ROM word-address width; matches the CPU instruction address space.
- MAX_WORDS, 32768, largest accepted program length in words.
- TIMEOUT, 1000000, idle clock cycles allowed between bytes of a frame before aborting; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; the transfer happens when rx_valid and rx_ready are both high.
- reload  input  1  single-cycle pulse; halts the CPU and restarts loading.
- rom_we  output  1  ROM write strobe, one cycle per word.
- rom_addr  output  ADDR_W  ROM write address.
- rom_wdata  output  16  ROM write data.
- cpu_reset  output  1  drives the CPU `reset` input.
- done  output  1  program loaded and CPU running.
- error  output  1  load aborted.

Behaviour:
- Reset, asynchronous:
  - state = LEN_LO.
  - cpu_reset = 1; rom_we = 0; rom_addr = 0; rom_wdata = 0; done = 0; error = 0.
  - Word counter, timeout counter and checksum are cleared.
- rx_ready is combinational from state: high in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK_LO/CHK_HI; low elsewhere. All other outputs are registered.
- Frame format, little-endian: len_lo, len_hi, then len words as (lo, hi) byte pairs, then (checksum lo, hi) when CHECKSUM_EN is defined.
- LEN_LO: on accept, latch the low length byte -> LEN_HI.
- LEN_HI: on accept, form len.
  - len == 0 -> RUN; no ROM writes.
  - len > MAX_WORDS -> ERROR.
  - otherwise -> DATA_LO, with rom_addr = 0.
- DATA_LO: on accept, latch the low byte -> DATA_HI.
- DATA_HI: on accept -> WRITE.
- WRITE: lasts exactly one cycle.
  - rom_we = 1, with rom_wdata = {hi, lo} and the current rom_addr.
  - The write strobe appears on the cycle after the hi byte is accepted.
  - The following cycle: rom_we = 0 and rom_addr increments.
  - Last word -> CHK_LO if CHECKSUM_EN, otherwise RUN. Other words -> DATA_LO.
- RUN:
  - cpu_reset drops on the first clock edge after entry; done = 1.
  - The CPU therefore starts fetching at PC 0 on the following cycle.
  - rx bytes are ignored (rx_ready = 0).
- ERROR: cpu_reset = 1 and error = 1. Exit only through reset or reload.
- reload: accepted in any state.
  - Next cycle: state = LEN_LO; cpu_reset = 1; done = 0; error = 0; counters and checksum cleared.
  - rom_addr = 0. Any partial word is discarded.
  - A reload arriving in the same cycle as a byte accept wins; that byte is dropped.
- Timeout:
  - The counter runs in LEN_HI, DATA_LO, DATA_HI, CHK_LO and CHK_HI.
  - It is cleared on every accepted byte.
  - Reaching TIMEOUT -> ERROR.
  - LEN_LO never times out, so the loader can idle waiting for a frame.
- Address wrap: impossible, because len <= MAX_WORDS <= 2^ADDR_W. rom_addr is never incremented past len.

Optional Feature:
- Macro BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - A 16-bit modulo-2^16 sum of all words is accumulated during WRITE.
  - After the last word, two further bytes (CHK_LO, CHK_HI) are received.
  - Match -> RUN; mismatch -> ERROR.
  - For len == 0, the checksum bytes are still expected, with expected value 0.
- Undefined: the CHK states, the accumulator and its comparison are not present; the last write goes directly to RUN.

Decomposition:
- Shared package `boot_pkg`:
  - state encoding localparams: LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHK_LO, CHK_HI, RUN, ERROR.
  - frame byte order constant.
- One natural sub-module, `idle_timer`: a loadable down-counter with clear and expire outputs, parameterised by TIMEOUT. It is omitted when TIMEOUT == 0.

Test Plan:
- Bytes 02 00 34 12 CD AB, no reload -> writes 0x1234 @0, then 0xABCD @1, one rom_we cycle each. cpu_reset falls 1 cycle after the second write; done = 1.
- Bytes 00 00 -> no rom_we; cpu_reset = 0 and done = 1 within 2 cycles after the len_hi accept.
- Bytes 01 80 (len 32769), with MAX_WORDS = 32768 -> error = 1, cpu_reset held 1, rx_ready = 0.
- TIMEOUT = 16: bytes 01 00 34, then silence -> error = 1 after 16 idle cycles. Pulsing reload afterwards -> error = 0, back in LEN_LO, rx_ready = 1.
- In RUN, pulse reload mid-execution, then send 01 00 FF 00 -> cpu_reset rises the next cycle; 0x00FF written @0; CPU released again.
- BOOT_LOADER_CHECKSUM_EN: bytes 01 00 34 12 34 12 -> RUN. Bytes 01 00 34 12 35 12 -> ERROR.
